// File: rtl/tmip_action_sched.sv
// Action scheduler for the TMIP datapath: buffers one action set, folds redundant
// flip/negative actions and hands commands to the datapath one at a time.
module tmip_action_sched #(
  parameter int MAX_ACT = 8,
  parameter int SETS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] image_size,
  input  logic       in_valid2,
  input  logic [2:0] action,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_op,
  output logic [1:0] cmd_size,
  input  logic       corr_done,
  output logic       set_done,
  output logic [2:0] set_cnt,
  output logic       busy,
  output logic       err
);

  localparam int         AW       = $clog2(MAX_ACT);
  localparam logic [3:0] QDEPTH   = 4'(MAX_ACT);
  localparam logic [2:0] SET_LAST = 3'(SETS - 1);

  localparam logic [2:0] OP_POOL = 3'd3;
  localparam logic [2:0] OP_NEG  = 3'd4;
  localparam logic [2:0] OP_FLIP = 3'd5;
  localparam logic [2:0] OP_MED  = 3'd6;
  localparam logic [2:0] OP_CORR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COLLECT   = 2'd1,
    S_ISSUE     = 2'd2,
    S_WAIT_CORR = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] queue_q [MAX_ACT];
  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] img_size_q, img_size_d;
  logic [1:0] cur_size_q, cur_size_d;
  logic       flip_q, flip_d;
  logic       neg_q, neg_d;
  logic       in_valid_q;
  logic       cmd_valid_q, cmd_valid_d;
  logic [2:0] cmd_op_q, cmd_op_d;
  logic [1:0] cmd_size_q, cmd_size_d;
  logic       set_done_q, set_done_d;
  logic [2:0] set_cnt_q, set_cnt_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  logic          wr_en_s;
  logic          err_set_s;
  logic          err_clr_s;
  logic          load_start_s;
  logic          busy_now_s;
  logic          can_load_s;
  logic          implicit_corr_s;
  logic          advance_s;
  logic [2:0]    entry_s;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] rd_idx_s;
  logic [AW-1:0] last_idx_s;

  assign wr_idx_s        = AW'(wr_ptr_q);
  assign rd_idx_s        = AW'(rd_ptr_q);
  assign last_idx_s      = AW'(wr_ptr_q - 4'd1);
  assign busy_now_s      = (state_q == S_ISSUE) || (state_q == S_WAIT_CORR);
  assign load_start_s    = in_valid && !in_valid_q && !busy_now_s;
  assign can_load_s      = !cmd_valid_q || cmd_ready;
  assign implicit_corr_s = (rd_ptr_q == wr_ptr_q);
  assign entry_s         = implicit_corr_s ? OP_CORR : queue_q[rd_idx_s];

  // Next-state, queue write and command selection
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    img_size_d = img_size_q;
    cur_size_d = cur_size_q;
    flip_d     = flip_q;
    neg_d      = neg_q;
    cmd_op_d   = cmd_op_q;
    cmd_size_d = cmd_size_q;
    set_cnt_d  = set_cnt_q;
    set_done_d = 1'b0;
    wr_en_s    = 1'b0;
    err_set_s  = 1'b0;
    err_clr_s  = 1'b0;
    advance_s  = 1'b0;

    if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
    end else begin
      cmd_valid_d = cmd_valid_q;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid2) begin
          wr_en_s  = 1'b1;
          wr_ptr_d = 4'd1;
          state_d  = S_COLLECT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_COLLECT: begin
        if (in_valid2) begin
          if (wr_ptr_q < QDEPTH) begin
            wr_en_s  = 1'b1;
            wr_ptr_d = wr_ptr_q + 4'd1;
          end else begin
            err_set_s = 1'b1;
          end
        end else begin
          state_d    = S_ISSUE;
          cur_size_d = img_size_q;
          rd_ptr_d   = 4'd0;
          flip_d     = 1'b0;
          neg_d      = 1'b0;
          err_set_s  = (queue_q[0] > 3'd2) || (queue_q[last_idx_s] != OP_CORR);
        end
      end

      S_ISSUE: begin
        // A new entry is evaluated only when the command slot is free this cycle
        if (can_load_s) begin
          case (entry_s)
            3'd0, 3'd1, 3'd2: begin
              advance_s = 1'b1;
              if (rd_ptr_q == 4'd0) begin
                cmd_valid_d = 1'b1;
                cmd_op_d    = entry_s;
                cmd_size_d  = cur_size_q;
              end else begin
                err_set_s = 1'b1;
              end
            end
            OP_NEG: begin
              neg_d     = !neg_q;
              advance_s = 1'b1;
            end
            OP_FLIP: begin
              flip_d    = !flip_q;
              advance_s = 1'b1;
            end
            OP_MED: begin
              cmd_valid_d = 1'b1;
              cmd_op_d    = OP_MED;
              cmd_size_d  = cur_size_q;
              advance_s   = 1'b1;
            end
            OP_POOL: begin
              if (cur_size_q == 2'd0) begin
                advance_s = 1'b1;
              end else if (neg_q) begin
                cmd_valid_d = 1'b1;
                cmd_op_d    = OP_NEG;
                cmd_size_d  = cur_size_q;
                neg_d       = 1'b0;
              end else begin
                cmd_valid_d = 1'b1;
                cmd_op_d    = OP_POOL;
                cmd_size_d  = cur_size_q;
                cur_size_d  = cur_size_q - 2'd1;
                advance_s   = 1'b1;
              end
            end
            OP_CORR: begin
              if (neg_q) begin
                cmd_valid_d = 1'b1;
                cmd_op_d    = OP_NEG;
                cmd_size_d  = cur_size_q;
                neg_d       = 1'b0;
              end else if (flip_q) begin
                cmd_valid_d = 1'b1;
                cmd_op_d    = OP_FLIP;
                cmd_size_d  = cur_size_q;
                flip_d      = 1'b0;
              end else begin
                cmd_valid_d = 1'b1;
                cmd_op_d    = OP_CORR;
                cmd_size_d  = cur_size_q;
                state_d     = S_WAIT_CORR;
                err_set_s   = !implicit_corr_s && ((rd_ptr_q + 4'd1) != wr_ptr_q);
              end
            end
            default: begin
              advance_s = 1'b1;
            end
          endcase
        end else begin
          advance_s = 1'b0;
        end
        rd_ptr_d = advance_s ? (rd_ptr_q + 4'd1) : rd_ptr_q;
      end

      S_WAIT_CORR: begin
        if (corr_done) begin
          set_done_d = 1'b1;
          set_cnt_d  = (set_cnt_q == SET_LAST) ? 3'd0 : (set_cnt_q + 3'd1);
          wr_ptr_d   = 4'd0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_WAIT_CORR;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_start_s) begin
      err_clr_s  = 1'b1;
      set_cnt_d  = 3'd0;
      img_size_d = (image_size == 2'd3) ? 2'd0 : image_size;
    end else begin
      err_clr_s = 1'b0;
    end

    // Illegal size and traffic while busy both latch the error flag
    if (err_set_s || (load_start_s && (image_size == 2'd3)) ||
        (busy_now_s && (in_valid || in_valid2))) begin
      err_d = 1'b1;
    end else if (err_clr_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT_CORR);
  end

  // State, queue and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= 4'd0;
      rd_ptr_q    <= 4'd0;
      img_size_q  <= 2'd0;
      cur_size_q  <= 2'd0;
      flip_q      <= 1'b0;
      neg_q       <= 1'b0;
      in_valid_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= 3'd0;
      cmd_size_q  <= 2'd0;
      set_done_q  <= 1'b0;
      set_cnt_q   <= 3'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < MAX_ACT; i++) begin
        queue_q[i] <= 3'd0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      img_size_q  <= img_size_d;
      cur_size_q  <= cur_size_d;
      flip_q      <= flip_d;
      neg_q       <= neg_d;
      in_valid_q  <= in_valid;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_size_q  <= cmd_size_d;
      set_done_q  <= set_done_d;
      set_cnt_q   <= set_cnt_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      if (wr_en_s) begin
        queue_q[wr_idx_s] <= action;
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_size  = cmd_size_q;
  assign set_done  = set_done_q;
  assign set_cnt   = set_cnt_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
